// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer: adds two WIDTH-bit operands three bits per cycle through an external 3-bit lookahead carry unit
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, cin)
//   g_o, p_o, c_o         generate/propagate/chunk carry-in to the lookahead unit (zero outside RUN)
//   c_i                   carries returned by the lookahead unit, c_i[k] = carry out of chunk bit k
//   out_valid/out_ready   result handshake (sum, cout, ovf)
module cla_chunk_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [2:0]       g_o,
    output logic [2:0]       p_o,
    output logic             c_o,
    input  logic [2:0]       c_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNKS = WIDTH / 3;
    localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    if (WIDTH % 3 != 0 || WIDTH < 3) begin : g_width_check
        $error("cla_chunk_sequencer: WIDTH must be a positive multiple of 3");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, ovf_q, ovf_d;
    logic run;
    logic [2:0] g, p;

    assign run = state_q == RUN;
    assign g = a_sh_q[2:0] & b_sh_q[2:0];
    assign p = a_sh_q[2:0] ^ b_sh_q[2:0];
    // Lookahead drive is purely registered and gated so the external unit sees zeros when idle.
    assign g_o = run ? g : 3'b000;
    assign p_o = run ? p : 3'b000;
    assign c_o = run & carry_q;
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum = sum_q;
    assign cout = carry_q;
    assign ovf = ovf_q;

    always_comb begin
        state_d = state_q;
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        carry_d = carry_q;
        ovf_d = ovf_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_sh_d = a;
                b_sh_d = b;
                carry_d = cin;
                cnt_d = '0;
                sum_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // Each bit's carry-in is the previous bit's carry-out from the lookahead unit.
                sum_d[3*cnt_q +: 3] = p ^ {c_i[1:0], carry_q};
                carry_d = c_i[2];
                a_sh_d = a_sh_q >> 3;
                b_sh_d = b_sh_q >> 3;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    ovf_d = c_i[2] ^ c_i[1];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q <= '0;
            b_sh_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
            carry_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            carry_q <= carry_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb_cla_chunk_sequencer: directed and random checks of cla_chunk_sequencer at WIDTH=12 and WIDTH=24
module tb_cla_chunk_sequencer;
    logic clk = 1'b0, rst = 1'b1, sel = 1'b0, iv = 1'b0, ordy = 1'b0, cin = 1'b0;
    logic [23:0] a = '0, b = '0;
    int comps = 0, fails = 0;

    logic rdy12, vld12, cout12, ovf12, co12, rdy24, vld24, cout24, ovf24, co24;
    logic [2:0] g12, p12, ci12, g24, p24, ci24;
    logic [11:0] sum12;
    logic [23:0] sum24;
    logic rdy, vld, cout, ovf, co;
    logic [2:0] g, p;
    logic [23:0] sm;

    cla_chunk_sequencer #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(rdy12), .a(a[11:0]), .b(b[11:0]),
        .cin(cin), .g_o(g12), .p_o(p12), .c_o(co12), .c_i(ci12), .out_valid(vld12),
        .out_ready(ordy & ~sel), .sum(sum12), .cout(cout12), .ovf(ovf12)
    );
    cla_chunk_sequencer #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(rdy24), .a(a), .b(b),
        .cin(cin), .g_o(g24), .p_o(p24), .c_o(co24), .c_i(ci24), .out_valid(vld24),
        .out_ready(ordy & sel), .sum(sum24), .cout(cout24), .ovf(ovf24)
    );

    // External 3-bit lookahead carry units.
    assign ci12[0] = g12[0] | p12[0] & co12;
    assign ci12[1] = g12[1] | p12[1] & g12[0] | p12[1] & p12[0] & co12;
    assign ci12[2] = g12[2] | p12[2] & g12[1] | p12[2] & p12[1] & g12[0] | p12[2] & p12[1] & p12[0] & co12;
    assign ci24[0] = g24[0] | p24[0] & co24;
    assign ci24[1] = g24[1] | p24[1] & g24[0] | p24[1] & p24[0] & co24;
    assign ci24[2] = g24[2] | p24[2] & g24[1] | p24[2] & p24[1] & g24[0] | p24[2] & p24[1] & p24[0] & co24;

    assign rdy = sel ? rdy24 : rdy12;
    assign vld = sel ? vld24 : vld12;
    assign cout = sel ? cout24 : cout12;
    assign ovf = sel ? ovf24 : ovf12;
    assign co = sel ? co24 : co12;
    assign g = sel ? g24 : g12;
    assign p = sel ? p24 : p12;
    assign sm = sel ? sum24 : {12'h000, sum12};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        comps++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b exp 1", rdy); end
        comps++; if (vld !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b exp 0", vld); end
        comps++; if (sm !== 24'h0) begin fails++; $display("FAIL reset sum got %h exp 0", sm); end
        comps++; if ({cout, ovf} !== 2'b00) begin fails++; $display("FAIL reset cout/ovf got %b exp 00", {cout, ovf}); end
        comps++; if ({g, p, co} !== 7'b0) begin fails++; $display("FAIL reset gpc got %b exp 0", {g, p, co}); end
        comps++; if (rdy24 !== 1'b1) begin fails++; $display("FAIL reset in_ready24 got %b exp 1", rdy24); end
        step;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic do_add(input logic [11:0] xa, input logic [11:0] xb, input logic xc,
                          input logic [2:0] eg, input logic [2:0] ep,
                          input logic [11:0] es, input logic ec, input logic eo, input bit drain);
        int n;
        a = {12'h000, xa};
        b = {12'h000, xb};
        cin = xc;
        iv = 1'b1;
        step;
        iv = 1'b0;
        comps++; if (rdy !== 1'b0) begin fails++; $display("FAIL add %h in_ready in RUN got %b exp 0", xa, rdy); end
        comps++; if (g !== eg) begin fails++; $display("FAIL add %h g_o got %b exp %b", xa, g, eg); end
        comps++; if (p !== ep) begin fails++; $display("FAIL add %h p_o got %b exp %b", xa, p, ep); end
        comps++; if (co !== xc) begin fails++; $display("FAIL add %h c_o got %b exp %b", xa, co, xc); end
        n = 0;
        while (!vld && n < 20) begin
            step;
            n++;
        end
        comps++; if (n != 4) begin fails++; $display("FAIL add %h latency got %0d exp 4", xa, n); end
        comps++; if (sm[11:0] !== es) begin fails++; $display("FAIL add %h sum got %h exp %h", xa, sm[11:0], es); end
        comps++; if (cout !== ec) begin fails++; $display("FAIL add %h cout got %b exp %b", xa, cout, ec); end
        comps++; if (ovf !== eo) begin fails++; $display("FAIL add %h ovf got %b exp %b", xa, ovf, eo); end
        comps++; if ({g, p, co} !== 7'b0) begin fails++; $display("FAIL add %h gpc in DONE got %b exp 0", xa, {g, p, co}); end
        if (drain) begin
            ordy = 1'b1;
            step;
            ordy = 1'b0;
            comps++; if ({rdy, vld} !== 2'b10) begin fails++; $display("FAIL add %h drain rdy/vld got %b exp 10", xa, {rdy, vld}); end
        end
    endtask

    task automatic test_basic;
        do_add(12'h0FF, 12'h001, 1'b0, 3'b001, 3'b110, 12'h100, 1'b0, 1'b0, 1'b1);
        do_add(12'hFFF, 12'h000, 1'b1, 3'b000, 3'b111, 12'h000, 1'b1, 1'b0, 1'b1);
        do_add(12'h7FF, 12'h001, 1'b0, 3'b001, 3'b110, 12'h800, 1'b0, 1'b1, 1'b1);
        do_add(12'h800, 12'h800, 1'b0, 3'b000, 3'b000, 12'h000, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_stall;
        do_add(12'hABC, 12'h123, 1'b0, 3'b000, 3'b111, 12'hBDF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = 24'h000555 + 24'(i);
            b = 24'h000333;
            iv = 1'b1;
            step;
            comps++; if (vld !== 1'b1) begin fails++; $display("FAIL stall%0d out_valid got %b exp 1", i, vld); end
            comps++; if (sm !== 24'h000BDF) begin fails++; $display("FAIL stall%0d sum got %h exp bdf", i, sm); end
            comps++; if ({rdy, cout} !== 2'b00) begin fails++; $display("FAIL stall%0d rdy/cout got %b exp 00", i, {rdy, cout}); end
            comps++; if ({g, p, co} !== 7'b0) begin fails++; $display("FAIL stall%0d gpc got %b exp 0", i, {g, p, co}); end
        end
        iv = 1'b0;
        ordy = 1'b1;
        step;
        ordy = 1'b0;
        comps++; if ({rdy, vld} !== 2'b10) begin fails++; $display("FAIL stall release rdy/vld got %b exp 10", {rdy, vld}); end
        do_add(12'h111, 12'h222, 1'b0, 3'b000, 3'b011, 12'h333, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        a = 24'h000FFF;
        b = 24'h000FFF;
        cin = 1'b0;
        iv = 1'b1;
        step;
        iv = 1'b0;
        step;
        rst = 1'b1;
        #1;
        comps++; if ({rdy, vld} !== 2'b10) begin fails++; $display("FAIL midrst rdy/vld got %b exp 10", {rdy, vld}); end
        comps++; if (sm !== 24'h0) begin fails++; $display("FAIL midrst sum got %h exp 0", sm); end
        comps++; if ({cout, ovf} !== 2'b00) begin fails++; $display("FAIL midrst cout/ovf got %b exp 00", {cout, ovf}); end
        comps++; if ({g, p, co} !== 7'b0) begin fails++; $display("FAIL midrst gpc got %b exp 0", {g, p, co}); end
        step;
        rst = 1'b0;
        step;
        comps++; if ({rdy, vld} !== 2'b10) begin fails++; $display("FAIL midrst after rdy/vld got %b exp 10", {rdy, vld}); end
        do_add(12'h123, 12'h456, 1'b0, 3'b010, 3'b101, 12'h579, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        int n;
        a = 24'h0000F0;
        b = 24'h00000F;
        cin = 1'b0;
        iv = 1'b1;
        ordy = 1'b1;
        step;
        a = 24'h000555;
        b = 24'h0002AA;
        n = 0;
        while (!vld && n < 20) begin
            step;
            n++;
        end
        comps++; if (sm !== 24'h0000FF) begin fails++; $display("FAIL b2b first sum got %h exp 0ff", sm); end
        n = 0;
        step;
        n++;
        while (!vld && n < 20) begin
            step;
            n++;
        end
        iv = 1'b0;
        comps++; if (n != 6) begin fails++; $display("FAIL b2b period got %0d exp 6", n); end
        comps++; if (sm !== 24'h0007FF) begin fails++; $display("FAIL b2b second sum got %h exp 7ff", sm); end
        step;
        ordy = 1'b0;
        comps++; if ({rdy, vld} !== 2'b10) begin fails++; $display("FAIL b2b end rdy/vld got %b exp 10", {rdy, vld}); end
    endtask

    task automatic test_random(input bit w24, input int cnt);
        int w, n, stall;
        logic [23:0] mask, es;
        logic [24:0] full;
        logic ec, eo;
        sel = w24;
        w = w24 ? 24 : 12;
        mask = w24 ? 24'hFFFFFF : 24'h000FFF;
        for (int t = 0; t < cnt; t++) begin
            a = 24'($urandom) & mask;
            b = 24'($urandom) & mask;
            cin = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + 25'(cin);
            es = full[23:0] & mask;
            ec = full[w];
            eo = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
            stall = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            ordy = stall == 0;
            iv = 1'b1;
            step;
            iv = 1'b0;
            n = 0;
            while (!vld && n < 50) begin
                step;
                n++;
            end
            comps++; if (n != w / 3) begin fails++; $display("FAIL rand%0d #%0d latency got %0d exp %0d", w, t, n, w / 3); end
            comps++; if (sm !== es) begin fails++; $display("FAIL rand%0d #%0d %h+%h+%b sum got %h exp %h", w, t, a, b, cin, sm, es); end
            comps++; if ({cout, ovf} !== {ec, eo}) begin fails++; $display("FAIL rand%0d #%0d cout/ovf got %b exp %b", w, t, {cout, ovf}, {ec, eo}); end
            comps++; if ({g, p, co} !== 7'b0) begin fails++; $display("FAIL rand%0d #%0d gpc in DONE got %b exp 0", w, t, {g, p, co}); end
            for (int s = 0; s < stall; s++) begin
                step;
                comps++; if (!vld || sm !== es || rdy) begin fails++; $display("FAIL rand%0d #%0d stall vld=%b rdy=%b sum got %h exp %h", w, t, vld, rdy, sm, es); end
            end
            ordy = 1'b1;
            step;
            comps++; if ({rdy, vld, g, p, co} !== 9'b100000000) begin fails++; $display("FAIL rand%0d #%0d idle state got %b exp 100000000", w, t, {rdy, vld, g, p, co}); end
        end
        ordy = 1'b0;
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
        $finish;
    end
endmodule
